// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch queue for the MSP430 core. It sits between the memory
// arbiter and the decoder. It runs ahead of decode, issuing sequential word
// fetches into a DEPTH-entry FIFO, and tags each stored word with the address
// it was fetched from. A program-counter redirect empties the queue and
// discards any response that belongs to the old instruction stream.
//
// Optional feature macro: FETCH_BYPASS_EN
//   When it is defined and the queue is empty, a response that is not being
//   dropped drives instr_out/instr_pc combinationally in its arrival cycle.
//   When it is undefined, the outputs come only from registered queue state.
//
// Parameters
//   SIZE   data/address width in bits
//   DEPTH  number of queue entries (power of two, >= 2)
//
// Ports
//   clk          system clock; all state updates on the rising edge
//   rst          asynchronous active-low reset
//   RST_VEC      boot fetch address, loaded in the single BOOT cycle
//   MAB_out      fetch address (always the current fetch_pc)
//   mem_req      fetch request
//   mem_gnt      arbiter grant; a fetch issues when mem_req & mem_gnt
//   MDB_in       read data, valid the cycle after the issuing cycle
//   instr_out    head word
//   instr_pc     fetch address of the head word
//   instr_valid  head word valid
//   instr_ready  decoder pop; a pop occurs when instr_valid & instr_ready
//   pc_load      redirect strobe (ignored in BOOT)
//   pc_new       redirect target
//   halt         suppresses new fetches; queued words still drain
//   count        stored entries, excluding the in-flight fetch
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int SIZE  = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SIZE-1:0]            RST_VEC,
    output logic [SIZE-1:0]            MAB_out,
    output logic                       mem_req,
    input  logic                       mem_gnt,
    input  logic [SIZE-1:0]            MDB_in,
    output logic [SIZE-1:0]            instr_out,
    output logic [SIZE-1:0]            instr_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    input  logic                       pc_load,
    input  logic [SIZE-1:0]            pc_new,
    input  logic                       halt,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [SIZE-1:0] fetch_pc;

    // Response stage: one fetch may be outstanding; its tag and drop flag
    // travel with it to the cycle its data appears on MDB_in.
    logic            vld_p1;
    logic            drop_p1;
    logic [SIZE-1:0] tag_p1;

    // Queue storage (data words are not reset; count gates their use)
    logic [SIZE-1:0] q_data [DEPTH];
    logic [SIZE-1:0] q_tag  [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;

    logic            run;
    logic            redirect;
    logic            q_empty;
    logic [CW:0]     occupancy;
    logic            fire;
    logic            resp_ok;
    logic            bypass;
    logic            pop;
    logic            fifo_pop;
    logic            push;

    // Sequential word address; wraps modulo 2^SIZE.
    function automatic logic [SIZE-1:0] next_word_addr(input logic [SIZE-1:0] pc);
        return pc + SIZE'(2);
    endfunction

    always_comb begin
        run       = (state == RUN);
        redirect  = run & pc_load;
        q_empty   = (count_q == '0);

        // The outstanding fetch already owns a slot, so a request is made
        // only when stored words plus the in-flight one leave room. This is
        // what makes a push at full impossible.
        occupancy = {1'b0, count_q} + (CW+1)'(vld_p1);
        mem_req   = run & ~halt & ~pc_load & (occupancy < (CW+1)'(DEPTH));
        fire      = mem_req & mem_gnt;

        resp_ok   = vld_p1 & ~drop_p1;

`ifdef FETCH_BYPASS_EN
        // A response arriving into an empty queue is presented directly; the
        // redirect cycle is excluded because that response is being discarded.
        bypass    = resp_ok & q_empty & ~redirect;
`else
        bypass    = 1'b0;
`endif

        instr_valid = ~q_empty | bypass;
        if (!q_empty) begin
            instr_out = q_data[rd_ptr];
            instr_pc  = q_tag[rd_ptr];
        end else if (bypass) begin
            instr_out = MDB_in;
            instr_pc  = tag_p1;
        end else begin
            instr_out = '0;
            instr_pc  = '0;
        end

        // A pop in the redirect cycle belongs to the abandoned stream.
        pop      = instr_valid & instr_ready & ~redirect;
        fifo_pop = pop & ~q_empty;
        // A bypassed word consumed in its arrival cycle is never stored.
        push     = resp_ok & ~redirect & ~(bypass & pop);
    end

    assign MAB_out = fetch_pc;
    assign count   = count_q;

    // ---- issue stage -> response stage (control) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            fetch_pc <= '0;
            vld_p1   <= 1'b0;
            drop_p1  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
        end else begin
            // In-flight flag follows the issue strobe: it clears in the
            // response cycle unless a new fetch issues in that same cycle.
            vld_p1  <= fire;
            // A fetch issued alongside a redirect belongs to the old stream;
            // its response is marked for discard.
            drop_p1 <= fire & redirect;

            case (state)
                BOOT: begin
                    fetch_pc <= RST_VEC;
                    state    <= RUN;
                end
                default: begin
                    if (redirect) begin
                        fetch_pc <= pc_new;
                    end else if (fire) begin
                        fetch_pc <= next_word_addr(fetch_pc);
                    end
                end
            endcase

            if (redirect) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (fifo_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, fifo_pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // ---- issue stage -> response stage (data) ----
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_p1 <= fetch_pc;
        end
    end

    // ---- response stage -> queue storage ----
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= MDB_in;
            q_tag[wr_ptr]  <= tag_p1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] RST_VEC;
    logic [15:0] MAB_out;
    logic        mem_req;
    logic        mem_gnt;
    logic [15:0] MDB_in;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        halt;
    logic [2:0]  count;

    fetch_queue #(.SIZE(16), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .RST_VEC     (RST_VEC),
        .MAB_out     (MAB_out),
        .mem_req     (mem_req),
        .mem_gnt     (mem_gnt),
        .MDB_in      (MDB_in),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_load     (pc_load),
        .pc_new      (pc_new),
        .halt        (halt),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } ent_t;

    ent_t        exp_q[$];
    logic [15:0] popped_pc[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    logic [15:0] model_pc;
    bit          resp_pend = 0;
    logic [15:0] resp_addr = '0;

    bit          o_valid, o_issue, o_req;
    logic [15:0] o_pc, o_mab;
    int          o_cyc;

    function automatic logic [15:0] data_of(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // One clock cycle: inputs already set by the caller, outputs sampled on
    // the falling edge, memory response driven just after the rising edge.
    task automatic cycle();
        ent_t        e;
        bit          exp_v;
        bit          nxt_pend;
        logic [15:0] nxt_addr;
        @(negedge clk);
        o_cyc = cyc;
        tests++;
        if (count !== 3'(exp_q.size())) begin
            fails++;
            $display("FAIL count cyc=%0d: got %0d expected %0d", cyc, count, exp_q.size());
        end
        exp_v = (exp_q.size() != 0);
`ifdef FETCH_BYPASS_EN
        exp_v = exp_v || (resp_pend && !pc_load);
`endif
        tests++;
        if (instr_valid !== exp_v) begin
            fails++;
            $display("FAIL instr_valid cyc=%0d: got %b expected %b", cyc, instr_valid, exp_v);
        end
        if (resp_pend) exp_q.push_back({resp_addr, data_of(resp_addr)});
        o_req   = mem_req;
        o_mab   = MAB_out;
        o_valid = instr_valid;
        o_pc    = instr_pc;
        o_issue = mem_req && mem_gnt;
        if (mem_req) begin
            tests++;
            if (MAB_out !== model_pc) begin
                fails++;
                $display("FAIL MAB_out cyc=%0d: got %h expected %h", cyc, MAB_out, model_pc);
            end
        end
        if (instr_valid && instr_ready && !pc_load) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop cyc=%0d: got word pc=%h expected none", cyc, instr_pc);
            end else begin
                e = exp_q.pop_front();
                if (instr_pc !== e.pc || instr_out !== e.data) begin
                    fails++;
                    $display("FAIL head cyc=%0d: got pc=%h data=%h expected pc=%h data=%h",
                             cyc, instr_pc, instr_out, e.pc, e.data);
                end
            end
            popped_pc.push_back(instr_pc);
        end
        nxt_pend = 0;
        nxt_addr = '0;
        if (pc_load) begin
            exp_q.delete();
            model_pc = pc_new;
        end else if (o_issue) begin
            nxt_pend = 1;
            nxt_addr = model_pc;
            model_pc = model_pc + 16'd2;
        end
        @(posedge clk);
        #1;
        resp_pend = nxt_pend;
        resp_addr = nxt_addr;
        MDB_in    = nxt_pend ? data_of(nxt_addr) : 16'hDEAD;
        cyc++;
    endtask

    task automatic redirect_to(input logic [15:0] target);
        pc_load = 1;
        pc_new  = target;
        cycle();
        pc_load = 0;
        popped_pc.delete();
    endtask

    task automatic test_reset();
        rst = 0; RST_VEC = 16'h4400; mem_gnt = 1; instr_ready = 1;
        pc_load = 0; pc_new = '0; halt = 0; MDB_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0 || count !== 3'd0) begin
            fails++;
            $display("FAIL reset_ctrl: got req=%b valid=%b count=%0d expected 0 0 0", mem_req, instr_valid, count);
        end
        tests++;
        if (instr_out !== 16'h0 || instr_pc !== 16'h0 || MAB_out !== 16'h0) begin
            fails++;
            $display("FAIL reset_data: got out=%h pc=%h mab=%h expected 0 0 0", instr_out, instr_pc, MAB_out);
        end
        @(posedge clk);
        #1;
        rst = 1;
        model_pc = 16'h4400;
    endtask

    task automatic test_boot();
        int r;
        int first_iss = -1;
        int first_val = -1;
        logic [15:0] iss_addr = '0;
        logic [15:0] val_pc = '0;
        int exp_lat;
        r = cyc;
        cycle();
        tests++;
        if (o_req !== 1'b0) begin
            fails++;
            $display("FAIL boot_req: got %b expected 0", o_req);
        end
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (o_issue && first_iss < 0) begin first_iss = o_cyc - r; iss_addr = o_mab; end
            if (o_valid && first_val < 0) begin first_val = o_cyc - r; val_pc = o_pc; end
        end
        tests++;
        if (first_iss !== 1 || iss_addr !== 16'h4400) begin
            fails++;
            $display("FAIL boot_issue: got cycle R+%0d addr %h expected R+1 4400", first_iss, iss_addr);
        end
`ifdef FETCH_BYPASS_EN
        exp_lat = 2;
`else
        exp_lat = 3;
`endif
        tests++;
        if (first_val !== exp_lat || val_pc !== 16'h4400) begin
            fails++;
            $display("FAIL boot_valid: got R+%0d pc %h expected R+%0d 4400", first_val, val_pc, exp_lat);
        end
    endtask

    task automatic test_fill_stall();
        int n = 0;
        instr_ready = 1;
        redirect_to(16'h5000);
        instr_ready = 0;
        for (int i = 0; i < 10; i++) begin cycle(); n += int'(o_issue); end
        tests++;
        if (n !== 4 || count !== 3'd4 || o_req !== 1'b0) begin
            fails++;
            $display("FAIL fill: got issues=%0d count=%0d req=%b expected 4 4 0", n, count, o_req);
        end
        instr_ready = 1;
        n = 0;
        cycle();
        n += int'(o_issue);
        instr_ready = 0;
        for (int i = 0; i < 6; i++) begin cycle(); n += int'(o_issue); end
        tests++;
        if (n !== 1 || count !== 3'd4) begin
            fails++;
            $display("FAIL refill: got issues=%0d count=%0d expected 1 4", n, count);
        end
    endtask

    task automatic test_redirect_inflight();
        int nc;
        int first_val = -1;
        int exp_lat;
        logic [15:0] val_pc = '0;
        bit seen_bad = 0;
        instr_ready = 1;
        redirect_to(16'h4400);
        for (int i = 0; i < 4; i++) cycle();
        tests++;
        if (!o_issue || o_mab !== 16'h4406) begin
            fails++;
            $display("FAIL setup_4406: got issue=%b addr=%h expected 1 4406", o_issue, o_mab);
        end
        nc = cyc;
        redirect_to(16'hC000);
        cycle();
        tests++;
        if (o_valid !== 1'b0 || o_mab !== 16'hC000) begin
            fails++;
            $display("FAIL redirect_n1: got valid=%b mab=%h expected 0 c000", o_valid, o_mab);
        end
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (o_valid && first_val < 0) begin first_val = o_cyc - nc; val_pc = o_pc; end
        end
`ifdef FETCH_BYPASS_EN
        exp_lat = 2;
`else
        exp_lat = 3;
`endif
        tests++;
        if (first_val !== exp_lat || val_pc !== 16'hC000) begin
            fails++;
            $display("FAIL redirect_first: got N+%0d pc %h expected N+%0d c000", first_val, val_pc, exp_lat);
        end
        foreach (popped_pc[i]) if (popped_pc[i] == 16'h4406) seen_bad = 1;
        tests++;
        if (seen_bad) begin
            fails++;
            $display("FAIL dropped_word: got pc 4406 output expected never");
        end
    endtask

    task automatic test_wrap();
        instr_ready = 1;
        redirect_to(16'hFFFE);
        for (int i = 0; i < 6; i++) cycle();
        tests++;
        if (popped_pc.size() < 2) begin
            fails++;
            $display("FAIL wrap: got %0d pops expected >=2", popped_pc.size());
        end else if (popped_pc[0] !== 16'hFFFE || popped_pc[1] !== 16'h0000) begin
            fails++;
            $display("FAIL wrap: got tags %h %h expected fffe 0000", popped_pc[0], popped_pc[1]);
        end
    endtask

    task automatic test_gnt_starve();
        logic [15:0] held;
        instr_ready = 1;
        mem_gnt = 0;
        held = MAB_out;
        for (int i = 0; i < 5; i++) begin
            cycle();
            tests++;
            if (o_mab !== held) begin
                fails++;
                $display("FAIL starve_hold %0d: got %h expected %h", i, o_mab, held);
            end
        end
        mem_gnt = 1;
        cycle();
        tests++;
        if (!o_issue || o_mab !== held) begin
            fails++;
            $display("FAIL starve_resume: got issue=%b addr=%h expected 1 %h", o_issue, o_mab, held);
        end
    endtask

    task automatic test_halt();
        bit req_seen = 0;
        instr_ready = 0;
        redirect_to(16'h6000);
        cycle();
        cycle();
        halt = 1;
        cycle();
        tests++;
        if (count !== 3'd2) begin
            fails++;
            $display("FAIL halt_queued: got count=%0d expected 2", count);
        end
        instr_ready = 1;
        for (int i = 0; i < 4; i++) begin cycle(); if (o_req) req_seen = 1; end
        tests++;
        if (count !== 3'd0 || req_seen || popped_pc.size() != 2) begin
            fails++;
            $display("FAIL halt_drain: got count=%0d req=%b pops=%0d expected 0 0 2", count, req_seen, popped_pc.size());
        end else if (popped_pc[0] !== 16'h6000 || popped_pc[1] !== 16'h6002) begin
            fails++;
            $display("FAIL halt_order: got %h %h expected 6000 6002", popped_pc[0], popped_pc[1]);
        end
    endtask

    task automatic test_reset_mid();
        int first_iss = -1;
        logic [15:0] iss_addr = '0;
        halt = 0;
        instr_ready = 0;
        redirect_to(16'h7000);
        for (int i = 0; i < 3; i++) cycle();
        halt = 1;
        cycle();
        tests++;
        if (count !== 3'd3) begin
            fails++;
            $display("FAIL mid_setup: got count=%0d expected 3", count);
        end
        @(negedge clk);
        #2;
        rst = 0;
        RST_VEC = 16'h8000;
        #1;
        tests++;
        if (instr_valid !== 1'b0 || count !== 3'd0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got valid=%b count=%0d req=%b expected 0 0 0", instr_valid, count, mem_req);
        end
        exp_q.delete();
        resp_pend = 0;
        halt = 0;
        instr_ready = 1;
        model_pc = 16'h8000;
        @(posedge clk);
        #1;
        rst = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (o_issue && first_iss < 0) begin first_iss = i; iss_addr = o_mab; end
        end
        tests++;
        if (first_iss !== 1 || iss_addr !== 16'h8000) begin
            fails++;
            $display("FAIL reboot: got cycle %0d addr %h expected 1 8000", first_iss, iss_addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_boot();
        test_fill_stall();
        test_redirect_inflight();
        test_wrap();
        test_gnt_starve();
        test_halt();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
